pwm_level_sequencer: RTL and testbench

//  Configuration/sequencing controller for the multilevel PWM level stages.

---
 rtl/pwm_pkg.sv | 14 +
 rtl/pwm_level_sequencer_if.sv | 29 ++
 rtl/seq_divider.sv | 68 ++++++
 rtl/pwm_level_sequencer.sv | 168 ++++++++++++++++
 tb/tb_pwm_level_sequencer.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/pwm_pkg.sv
// Shared types and defaults for the multilevel PWM level sequencer.
package pwm_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DIV   = 2'd1,
      ST_WRITE = 2'd2,
      ST_RUN   = 2'd3
   } seq_state_e;

   localparam int DEF_BIT_WIDTH   = 16;
   localparam int DEF_LEVEL_COUNT = 4;

endpackage

// File: rtl/pwm_level_sequencer_if.sv
// Config handshake plus per-level register write bus between the config
// registers (master side) and the level sequencer (slave side).
interface pwm_level_sequencer_if
   import pwm_pkg::*;
#(
   parameter int BIT_WIDTH = DEF_BIT_WIDTH,
   parameter int IDX_W     = 2
);
   logic                 CfgValid;
   logic                 CfgReady;
   logic [BIT_WIDTH-1:0] CfgMaxCount;
   logic                 CfgInterleave;
   logic                 StopReq;
   logic                 WrEn;
   logic [IDX_W-1:0]     WrIdx;
   logic [BIT_WIDTH-1:0] WrLower;
   logic [BIT_WIDTH-1:0] WrUpper;
   logic [BIT_WIDTH-1:0] WrOffset;

   modport master (
      output CfgValid, CfgMaxCount, CfgInterleave, StopReq,
      input  CfgReady, WrEn, WrIdx, WrLower, WrUpper, WrOffset
   );

   modport slave (
      input  CfgValid, CfgMaxCount, CfgInterleave, StopReq,
      output CfgReady, WrEn, WrIdx, WrLower, WrUpper, WrOffset
   );
endinterface

// File: rtl/seq_divider.sv
// Restoring shift-subtract divider by a constant; the first step happens on
// the start edge, so the quotient is ready (done=1) BIT_WIDTH cycles later.
module seq_divider
   import pwm_pkg::*;
#(
   parameter int BIT_WIDTH = DEF_BIT_WIDTH,
   parameter int DIVISOR   = DEF_LEVEL_COUNT
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [BIT_WIDTH-1:0] dividend,
   output logic [BIT_WIDTH-1:0] quotient,
   output logic                 done
);
   localparam int                 CNT_W   = $clog2(BIT_WIDTH + 1);
   localparam logic [BIT_WIDTH:0] DIV_EXT = (BIT_WIDTH + 1)'(DIVISOR);

   logic [BIT_WIDTH-1:0] rem_q, rem_d;
   logic [BIT_WIDTH-1:0] quo_q, quo_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic                 run_q, run_d;
   logic [BIT_WIDTH-1:0] src_rem, src_quo;
   logic [BIT_WIDTH:0]   rem_sh;

   always_comb begin
      rem_d   = rem_q;
      quo_d   = quo_q;
      cnt_d   = cnt_q;
      run_d   = run_q;
      src_rem = start ? '0 : rem_q;
      src_quo = start ? dividend : quo_q;
      rem_sh  = {src_rem, src_quo[BIT_WIDTH-1]};
      if (start || (cnt_q != '0)) begin
         // quotient bits shift in from the right as dividend bits shift out
         if (rem_sh >= DIV_EXT) begin
            rem_d = BIT_WIDTH'(rem_sh - DIV_EXT);
            quo_d = {src_quo[BIT_WIDTH-2:0], 1'b1};
         end else begin
            rem_d = rem_sh[BIT_WIDTH-1:0];
            quo_d = {src_quo[BIT_WIDTH-2:0], 1'b0};
         end
         cnt_d = start ? CNT_W'(BIT_WIDTH - 1) : cnt_q - CNT_W'(1);
      end
      if (start)
         run_d = 1'b1;
      else if (cnt_q == '0)
         run_d = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rem_q <= '0;
         quo_q <= '0;
         cnt_q <= '0;
         run_q <= 1'b0;
      end else begin
         rem_q <= rem_d;
         quo_q <= quo_d;
         cnt_q <= cnt_d;
         run_q <= run_d;
      end
   end

   assign quotient = quo_q;
   assign done     = run_q && (cnt_q == '0);

endmodule

// File: rtl/pwm_level_sequencer.sv
// Computes each level's carrier band and interleave offset from the max count,
// writes them to the level stages, then releases a common run enable.
module pwm_level_sequencer
   import pwm_pkg::*;
#(
   parameter int LEVEL_COUNT = DEF_LEVEL_COUNT,
   parameter int BIT_WIDTH   = DEF_BIT_WIDTH
) (
   input  logic                   MClk,
   input  logic                   RstN,
   pwm_level_sequencer_if.slave   bus,
   output logic                   RunEn,
   output logic                   Busy,
   output logic                   CfgErr
);
   localparam int IDX_W = $clog2(LEVEL_COUNT);
   localparam int CNT_W = IDX_W + 1;

   seq_state_e           state_q, state_d;
   logic                 interleave_q, interleave_d;
   logic [BIT_WIDTH-1:0] q_q, q_d;
   logic [BIT_WIDTH-1:0] acc_q, acc_d;
   logic [CNT_W-1:0]     idx_q, idx_d;
   logic                 run_en_q, run_en_d;
   logic                 cfg_err_q, cfg_err_d;
   logic                 wr_en_q, wr_en_d;
   logic [IDX_W-1:0]     wr_idx_q, wr_idx_d;
   logic [BIT_WIDTH-1:0] wr_lower_q, wr_lower_d;
   logic [BIT_WIDTH-1:0] wr_upper_q, wr_upper_d;
   logic [BIT_WIDTH-1:0] wr_offset_q, wr_offset_d;

   logic                 cfg_ready, accept;
   logic                 div_start, div_done;
   logic [BIT_WIDTH-1:0] div_quo;
   logic                 issue;
   logic [CNT_W-1:0]     issue_idx;
   logic [BIT_WIDTH-1:0] wr_base, wr_step;

   assign cfg_ready = ((state_q == ST_IDLE) || (state_q == ST_RUN)) && !bus.StopReq;
   assign accept    = bus.CfgValid && cfg_ready;

   seq_divider #(
      .BIT_WIDTH (BIT_WIDTH),
      .DIVISOR   (LEVEL_COUNT)
   ) u_div (
      .clk      (MClk),
      .rst_n    (RstN),
      .start    (div_start),
      .dividend (bus.CfgMaxCount),
      .quotient (div_quo),
      .done     (div_done)
   );

   always_comb begin
      state_d      = state_q;
      interleave_d = interleave_q;
      q_d          = q_q;
      acc_d        = acc_q;
      idx_d        = idx_q;
      run_en_d     = run_en_q;
      cfg_err_d    = cfg_err_q;
      wr_en_d      = 1'b0;
      wr_idx_d     = '0;
      wr_lower_d   = '0;
      wr_upper_d   = '0;
      wr_offset_d  = '0;
      div_start    = 1'b0;
      issue        = 1'b0;
      issue_idx    = idx_q;
      wr_base      = acc_q;
      wr_step      = q_q;

      case (state_q)
         ST_IDLE, ST_RUN: begin
            if ((state_q == ST_RUN) && bus.StopReq) begin
               state_d  = ST_IDLE;
               run_en_d = 1'b0;
            end else if (accept) begin
               state_d      = ST_DIV;
               interleave_d = bus.CfgInterleave;
               run_en_d     = 1'b0;
               cfg_err_d    = 1'b0;
               div_start    = 1'b1;
            end
         end
         ST_DIV: begin
            if (bus.StopReq) begin
               state_d = ST_IDLE;
            end else if (div_done) begin
               if (div_quo == '0) begin
                  cfg_err_d = 1'b1;
                  state_d   = ST_IDLE;
               end else begin
                  // level 0 goes out on the same edge the quotient lands
                  q_d       = div_quo;
                  wr_base   = '0;
                  wr_step   = div_quo;
                  issue_idx = '0;
                  issue     = 1'b1;
                  state_d   = ST_WRITE;
               end
            end
         end
         ST_WRITE: begin
            if (bus.StopReq) begin
               state_d = ST_IDLE;
            end else if (idx_q == CNT_W'(LEVEL_COUNT)) begin
               state_d  = ST_RUN;
               run_en_d = 1'b1;
            end else begin
               issue = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (issue) begin
         wr_en_d     = 1'b1;
         wr_idx_d    = issue_idx[IDX_W-1:0];
         wr_lower_d  = wr_base;
         wr_upper_d  = wr_base + wr_step - BIT_WIDTH'(1);
         wr_offset_d = interleave_q ? wr_base : '0;
         acc_d       = wr_base + wr_step;
         idx_d       = issue_idx + CNT_W'(1);
      end
   end

   always_ff @(posedge MClk or negedge RstN) begin
      if (!RstN) begin
         state_q      <= ST_IDLE;
         interleave_q <= 1'b0;
         q_q          <= '0;
         acc_q        <= '0;
         idx_q        <= '0;
         run_en_q     <= 1'b0;
         cfg_err_q    <= 1'b0;
         wr_en_q      <= 1'b0;
         wr_idx_q     <= '0;
         wr_lower_q   <= '0;
         wr_upper_q   <= '0;
         wr_offset_q  <= '0;
      end else begin
         state_q      <= state_d;
         interleave_q <= interleave_d;
         q_q          <= q_d;
         acc_q        <= acc_d;
         idx_q        <= idx_d;
         run_en_q     <= run_en_d;
         cfg_err_q    <= cfg_err_d;
         wr_en_q      <= wr_en_d;
         wr_idx_q     <= wr_idx_d;
         wr_lower_q   <= wr_lower_d;
         wr_upper_q   <= wr_upper_d;
         wr_offset_q  <= wr_offset_d;
      end
   end

   assign bus.CfgReady = cfg_ready;
   assign bus.WrEn     = wr_en_q;
   assign bus.WrIdx    = wr_idx_q;
   assign bus.WrLower  = wr_lower_q;
   assign bus.WrUpper  = wr_upper_q;
   assign bus.WrOffset = wr_offset_q;
   assign RunEn        = run_en_q;
   assign CfgErr       = cfg_err_q;
   assign Busy         = (state_q == ST_DIV) || (state_q == ST_WRITE);

endmodule

// File: tb/tb_pwm_level_sequencer.sv
// Directed table-driven bench for pwm_level_sequencer (LEVEL_COUNT=4, BIT_WIDTH=16).
module tb_pwm_level_sequencer;
   import pwm_pkg::*;

   logic MClk = 1'b0;
   logic RstN = 1'b0;
   logic RunEn, Busy, CfgErr;

   pwm_level_sequencer_if #(.BIT_WIDTH(16), .IDX_W(2)) bus ();

   pwm_level_sequencer #(.LEVEL_COUNT(4), .BIT_WIDTH(16)) dut (
      .MClk   (MClk),
      .RstN   (RstN),
      .bus    (bus),
      .RunEn  (RunEn),
      .Busy   (Busy),
      .CfgErr (CfgErr)
   );

   always #5 MClk = ~MClk;

   typedef struct {
      logic [15:0] mx;
      logic        il;
      int          q;
      logic        err;
   } vec_t;

   vec_t vecs[6];
   int   n_vec = 0;
   int   n_err = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge MClk);
      #1;
   endtask

   // Offer a config and take the accepting edge; returns at cycle k+1.
   task automatic handshake(input logic [15:0] mx, input logic il);
      bus.CfgValid      = 1'b1;
      bus.CfgMaxCount   = mx;
      bus.CfgInterleave = il;
      #1;
      chk("handshake CfgReady", 32'(bus.CfgReady), 32'd1);
      tick();
      bus.CfgValid = 1'b0;
   endtask

   task automatic run_vec(input int id, input vec_t v);
      logic wr;
      int   i;
      handshake(v.mx, v.il);
      for (int c = 1; c <= 22; c++) begin
         if (c > 1) tick();
         wr = !v.err && (c >= 17) && (c <= 20);
         i  = c - 17;
         chk($sformatf("v%0d c%0d WrEn", id, c), 32'(bus.WrEn), 32'(wr));
         if (wr) begin
            chk($sformatf("v%0d c%0d WrIdx", id, c), 32'(bus.WrIdx), 32'(i));
            chk($sformatf("v%0d c%0d WrLower", id, c), 32'(bus.WrLower), 32'(i * v.q));
            chk($sformatf("v%0d c%0d WrUpper", id, c), 32'(bus.WrUpper), 32'(i * v.q + v.q - 1));
            chk($sformatf("v%0d c%0d WrOffset", id, c), 32'(bus.WrOffset),
                v.il ? 32'(i * v.q) : 32'd0);
         end
         chk($sformatf("v%0d c%0d RunEn", id, c), 32'(RunEn), 32'(!v.err && (c >= 21)));
         chk($sformatf("v%0d c%0d Busy", id, c), 32'(Busy),
             32'((c <= 16) || (!v.err && (c <= 20))));
         chk($sformatf("v%0d c%0d CfgErr", id, c), 32'(CfgErr), 32'(v.err && (c >= 17)));
      end
      chk($sformatf("v%0d end CfgReady", id), 32'(bus.CfgReady), 32'd1);
   endtask

   initial begin
      int wr_seen;
      vecs[0] = '{16'd1000,  1'b1, 250,   1'b0};
      vecs[1] = '{16'd1003,  1'b0, 250,   1'b0};
      vecs[2] = '{16'd3,     1'b1, 0,     1'b1};
      vecs[3] = '{16'd4,     1'b0, 1,     1'b0};
      vecs[4] = '{16'd2000,  1'b1, 500,   1'b0};
      vecs[5] = '{16'd65535, 1'b1, 16383, 1'b0};

      bus.CfgValid      = 1'b0;
      bus.CfgMaxCount   = '0;
      bus.CfgInterleave = 1'b0;
      bus.StopReq       = 1'b0;

      // reset state
      tick();
      tick();
      chk("rst RunEn", 32'(RunEn), 32'd0);
      chk("rst Busy", 32'(Busy), 32'd0);
      chk("rst CfgErr", 32'(CfgErr), 32'd0);
      chk("rst WrEn", 32'(bus.WrEn), 32'd0);
      chk("rst WrUpper", 32'(bus.WrUpper), 32'd0);
      chk("rst CfgReady", 32'(bus.CfgReady), 32'd1);
      RstN = 1'b1;

      foreach (vecs[v]) run_vec(v, vecs[v]);

      // StopReq beats CfgValid in RUN
      bus.StopReq     = 1'b1;
      bus.CfgValid    = 1'b1;
      bus.CfgMaxCount = 16'd2000;
      #1;
      chk("stop+cfg CfgReady", 32'(bus.CfgReady), 32'd0);
      tick();
      bus.StopReq  = 1'b0;
      bus.CfgValid = 1'b0;
      #1;
      chk("stop+cfg RunEn", 32'(RunEn), 32'd0);
      chk("stop+cfg Busy", 32'(Busy), 32'd0);
      chk("stop+cfg CfgReady", 32'(bus.CfgReady), 32'd1);
      wr_seen = 0;
      for (int c = 0; c < 22; c++) begin
         tick();
         wr_seen += int'(bus.WrEn) + int'(RunEn);
      end
      chk("stop+cfg idle activity", 32'(wr_seen), 32'd0);

      // CfgValid held during DIV is ignored
      handshake(16'd1000, 1'b1);
      for (int c = 1; c <= 22; c++) begin
         if (c > 1) tick();
         if (c == 3) begin
            bus.CfgValid    = 1'b1;
            bus.CfgMaxCount = 16'd40;
            #1;
            chk("div CfgReady", 32'(bus.CfgReady), 32'd0);
         end
         if (c == 9) bus.CfgValid = 1'b0;
         if (c == 18) begin
            chk("div-ign WrIdx", 32'(bus.WrIdx), 32'd1);
            chk("div-ign WrLower", 32'(bus.WrLower), 32'd250);
         end
         if (c == 20) begin
            chk("div-ign WrUpper", 32'(bus.WrUpper), 32'd999);
            chk("div-ign RunEn early", 32'(RunEn), 32'd0);
         end
         if (c == 21) chk("div-ign RunEn", 32'(RunEn), 32'd1);
      end

      // StopReq mid-WRITE aborts to IDLE
      handshake(16'd1000, 1'b0);
      for (int c = 2; c <= 18; c++) tick();
      chk("wr-stop WrEn before", 32'(bus.WrEn), 32'd1);
      bus.StopReq = 1'b1;
      tick();
      bus.StopReq = 1'b0;
      #1;
      chk("wr-stop WrEn", 32'(bus.WrEn), 32'd0);
      chk("wr-stop Busy", 32'(Busy), 32'd0);
      chk("wr-stop CfgReady", 32'(bus.CfgReady), 32'd1);
      wr_seen = 0;
      for (int c = 0; c < 5; c++) begin
         tick();
         wr_seen += int'(bus.WrEn) + int'(RunEn);
      end
      chk("wr-stop idle activity", 32'(wr_seen), 32'd0);

      // async reset clears sticky error, then mid-DIV, then mid-WRITE
      run_vec(10, vecs[2]);
      RstN = 1'b0;
      #1;
      chk("rst CfgErr clear", 32'(CfgErr), 32'd0);
      RstN = 1'b1;
      tick();
      handshake(16'd1000, 1'b1);
      for (int c = 2; c <= 5; c++) tick();
      chk("mid-div Busy before", 32'(Busy), 32'd1);
      RstN = 1'b0;
      #1;
      chk("mid-div Busy", 32'(Busy), 32'd0);
      chk("mid-div CfgReady", 32'(bus.CfgReady), 32'd1);
      RstN = 1'b1;
      tick();
      handshake(16'd1000, 1'b1);
      for (int c = 2; c <= 18; c++) tick();
      chk("mid-wr WrEn before", 32'(bus.WrEn), 32'd1);
      RstN = 1'b0;
      #1;
      chk("mid-wr WrEn", 32'(bus.WrEn), 32'd0);
      chk("mid-wr WrLower", 32'(bus.WrLower), 32'd0);
      chk("mid-wr WrOffset", 32'(bus.WrOffset), 32'd0);
      chk("mid-wr Busy", 32'(Busy), 32'd0);
      chk("mid-wr RunEn", 32'(RunEn), 32'd0);
      chk("mid-wr CfgReady", 32'(bus.CfgReady), 32'd1);
      RstN = 1'b1;
      tick();
      run_vec(11, vecs[0]);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
